// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : RV32I decode/issue stage producing ALU control and operands,
//            registered behind a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
   parameter logic [6:0] RESET_CTL = 7'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] csr_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  alu_ctl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        illegal
);

   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] c_ALU_ADD = 4'b0010;
   localparam logic [3:0] c_ALU_SUB = 4'b0110;

   // Payload layout: {illegal, alu_ctl, alu_a, alu_b}
   localparam int c_PAY_W = 72;
   localparam logic [c_PAY_W-1:0] c_RESET_PAY = {1'b0, RESET_CTL, 64'd0};

   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

   state_t               r_state;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [c_PAY_W-1:0]   r_out_pay;
   logic [c_PAY_W-1:0]   r_skid_pay;

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic        w_f7b5;
   logic [6:0]  w_ctl;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic        w_ill;
   logic [c_PAY_W-1:0] w_dec_pay;
   logic        w_xfer_in;
   logic        w_xfer_out;
   logic        w_unused_instr;

   assign w_opc          = instr[6:0];
   assign w_f3           = instr[14:12];
   assign w_f7b5         = instr[30];
   assign w_unused_instr = ^{instr[31], instr[29:20], instr[11:7]};

   // Shared OP / OP-IMM table; SUB only exists for register-register ops.
   function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic f7b5,
                                           input logic sub_ok);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (sub_ok && f7b5) ? 4'b0110 : 4'b0010;
         3'b001:  op = 4'b0100;
         3'b010,
         3'b011:  op = 4'b0111;
         3'b100:  op = 4'b1000;
         3'b101:  op = f7b5 ? 4'b0101 : 4'b0011;
         3'b110:  op = 4'b0001;
         default: op = 4'b0000;
      endcase
      return op;
   endfunction

   always_comb begin
      w_ctl = 7'd0;
      w_a   = 32'd0;
      w_b   = 32'd0;
      w_ill = 1'b0;
      case (w_opc)
         c_OPC_OP: begin
            w_ctl = {3'b000, f_alu_op(w_f3, w_f7b5, 1'b1)};
            w_a   = rs1_data;
            w_b   = rs2_data;
         end
         c_OPC_OPIMM: begin
            w_ctl = {3'b000, f_alu_op(w_f3, w_f7b5, 1'b0)};
            w_a   = rs1_data;
            w_b   = imm;
         end
         c_OPC_LOAD, c_OPC_STORE: begin
            w_ctl = {3'b000, c_ALU_ADD};
            w_a   = rs1_data;
            w_b   = imm;
         end
         c_OPC_AUIPC: begin
            w_ctl = {3'b000, c_ALU_ADD};
            w_a   = pc;
            w_b   = imm;
         end
         c_OPC_LUI: begin
            w_ctl = {3'b000, c_ALU_ADD};
            w_b   = imm;
         end
         c_OPC_JAL, c_OPC_JALR: begin
            w_ctl = {3'b000, c_ALU_ADD};
            w_a   = pc;
            w_b   = 32'd4;
         end
         c_OPC_BRANCH: begin
            w_a = rs1_data;
            w_b = rs2_data;
            case (w_f3)
               3'b000:  w_ctl = {3'b001, c_ALU_SUB};
               3'b001:  w_ctl = {3'b010, c_ALU_SUB};
               3'b100:  w_ctl = {3'b011, c_ALU_SUB};
               3'b101:  w_ctl = {3'b100, c_ALU_SUB};
               3'b110:  w_ctl = {3'b101, c_ALU_SUB};
               3'b111:  w_ctl = {3'b110, c_ALU_SUB};
               default: begin
                  w_ctl = {3'b000, c_ALU_SUB};
                  w_ill = 1'b1;
               end
            endcase
         end
         c_OPC_SYSTEM: begin
            // f3[1:0]==00 (ECALL/EBREAK etc.) passes through as a no-op code.
            case (w_f3[1:0])
               2'b01:   w_ctl = 7'b000_1001;
               2'b10:   w_ctl = 7'b000_1010;
               2'b11:   w_ctl = 7'b000_1011;
               default: w_ctl = 7'd0;
            endcase
            w_a = w_f3[2] ? {27'd0, instr[19:15]} : rs1_data;
            w_b = csr_rdata;
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign w_dec_pay  = {w_ill, w_ctl, w_a, w_b};
   assign w_xfer_in  = in_valid && r_in_ready;
   assign w_xfer_out = r_out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_pay   <= c_RESET_PAY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_xfer_in) begin
                  r_out_pay   <= w_dec_pay;
                  r_out_valid <= 1'b1;
                  r_state     <= S_ONE;
               end
            end
            S_ONE: begin
               if (w_xfer_in && !w_xfer_out) begin
                  r_skid_pay <= w_dec_pay;
                  r_in_ready <= 1'b0;
                  r_state    <= S_TWO;
               end else if (w_xfer_in) begin
                  r_out_pay <= w_dec_pay;
               end else if (w_xfer_out) begin
                  r_out_pay   <= c_RESET_PAY;
                  r_out_valid <= 1'b0;
                  r_state     <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_xfer_out) begin
                  r_out_pay  <= r_skid_pay;
                  r_in_ready <= 1'b1;
                  r_state    <= S_ONE;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_out_pay   <= c_RESET_PAY;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign illegal   = r_out_pay[71];
   assign alu_ctl   = r_out_pay[70:64];
   assign alu_a     = r_out_pay[63:32];
   assign alu_b     = r_out_pay[31:0];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Directed self-checking bench for alu_issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [31:0] instr, pc, imm, rs1_data, rs2_data, csr_rdata, alu_a, alu_b;
   logic [6:0]  alu_ctl;
   logic [71:0] got;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   alu_issue #(.RESET_CTL(7'h00)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .imm(imm),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_rdata(csr_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .illegal(illegal)
   );

   assign got = {illegal, alu_ctl, alu_a, alu_b};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] c);
      instr = i; pc = p; imm = im; rs1_data = r1; rs2_data = r2; csr_rdata = c;
   endtask

   task automatic test_reset;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      step; step;
      reset = 1'b0;
      total++;
      if ({out_valid, in_ready, got} !== {1'b0, 1'b1, 72'd0}) begin
         bad++;
         $display("FAIL reset: got v=%b r=%b pay=%h exp v=0 r=1 pay=0", out_valid, in_ready, got);
      end
   endtask

   task automatic test_add;
      out_ready = 1'b1;
      drive(32'h002081B3, 32'h0, 32'h0, 32'd5, 32'd7, 32'h0);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      total++;
      if ({out_valid, got} !== {1'b1, 1'b0, 7'h02, 32'd5, 32'd7}) begin
         bad++;
         $display("FAIL add: got v=%b pay=%h exp v=1 ctl=02 a=5 b=7", out_valid, got);
      end
      step;
      total++;
      if ({out_valid, in_ready, got} !== {1'b0, 1'b1, 72'd0}) begin
         bad++;
         $display("FAIL add_drain: got v=%b r=%b pay=%h exp empty", out_valid, in_ready, got);
      end
   endtask

   task automatic test_decode;
      logic [71:0] exp_pay [10];
      logic [31:0] vec [10][6];
      vec[0] = '{ {7'b0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011}, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0 };
      exp_pay[0] = {1'b0, 7'h36, 32'hFFFFFFFF, 32'd1};
      vec[1] = '{ {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd3, 7'b0010011}, 32'h0, 32'd3, 32'h80000000, 32'd9, 32'h0 };
      exp_pay[1] = {1'b0, 7'h05, 32'h80000000, 32'd3};
      vec[2] = '{ {12'h300, 5'h1F, 3'b111, 5'd0, 7'b1110011}, 32'h0, 32'h0, 32'h1234, 32'h0, 32'hA5 };
      exp_pay[2] = {1'b0, 7'h0B, 32'h1F, 32'hA5};
      vec[3] = '{ {20'h00002, 5'd1, 7'b0010111}, 32'h100, 32'h2000, 32'h77, 32'h0, 32'h0 };
      exp_pay[3] = {1'b0, 7'h02, 32'h100, 32'h2000};
      vec[4] = '{ {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h0, 32'h0, 32'd10, 32'd3, 32'h0 };
      exp_pay[4] = {1'b0, 7'h06, 32'd10, 32'd3};
      vec[5] = '{ {7'b0100000, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0010011}, 32'h0, 32'hFFFFFFFF, 32'd10, 32'd3, 32'h0 };
      exp_pay[5] = {1'b0, 7'h02, 32'd10, 32'hFFFFFFFF};
      vec[6] = '{ {20'h12345, 5'd1, 7'b0110111}, 32'h200, 32'h12345000, 32'd7, 32'd8, 32'h0 };
      exp_pay[6] = {1'b0, 7'h02, 32'd0, 32'h12345000};
      vec[7] = '{ {20'h0, 5'd1, 7'b1101111}, 32'h40, 32'h800, 32'd7, 32'd8, 32'h0 };
      exp_pay[7] = {1'b0, 7'h02, 32'h40, 32'd4};
      vec[8] = '{ 32'h00000000, 32'h40, 32'h800, 32'd7, 32'd8, 32'h9 };
      exp_pay[8] = {1'b1, 7'h00, 32'd0, 32'd0};
      vec[9] = '{ {7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011}, 32'h0, 32'h0, 32'd4, 32'd6, 32'h0 };
      exp_pay[9] = {1'b1, 7'h06, 32'd4, 32'd6};
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(vec[k][0], vec[k][1], vec[k][2], vec[k][3], vec[k][4], vec[k][5]);
         in_valid = 1'b1;
         step;
         in_valid = 1'b0;
         total++;
         if ({out_valid, got} !== {1'b1, exp_pay[k]}) begin
            bad++;
            $display("FAIL decode[%0d]: got v=%b pay=%h exp v=1 pay=%h", k, out_valid, got, exp_pay[k]);
         end
         step;
      end
      // CSRRS with register source, then ECALL-like no-op
      drive({12'h300, 5'd1, 3'b010, 5'd2, 7'b1110011}, 32'h0, 32'h0, 32'h55, 32'h0, 32'hF0);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      total++;
      if (got !== {1'b0, 7'h0A, 32'h55, 32'hF0}) begin
         bad++;
         $display("FAIL csrrs: got pay=%h exp ctl=0a a=55 b=f0", got);
      end
      step;
      drive(32'h00000073, 32'h0, 32'h0, 32'h55, 32'h0, 32'hF0);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      total++;
      if ({out_valid, illegal, alu_ctl} !== {1'b1, 1'b0, 7'h00}) begin
         bad++;
         $display("FAIL ecall: got v=%b ill=%b ctl=%h exp v=1 ill=0 ctl=00", out_valid, illegal, alu_ctl);
      end
      step;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      drive(32'h002081B3, 32'h0, 32'h0, 32'd1, 32'd0, 32'h0);
      in_valid = 1'b1;
      step;
      total++;
      if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b1, 32'd1}) begin
         bad++;
         $display("FAIL b2b_first: got v=%b r=%b a=%h exp v=1 r=1 a=1", out_valid, in_ready, alu_a);
      end
      drive(32'h002081B3, 32'h0, 32'h0, 32'd2, 32'd0, 32'h0);
      step;
      total++;
      if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b0, 32'd1}) begin
         bad++;
         $display("FAIL b2b_full: got v=%b r=%b a=%h exp v=1 r=0 a=1", out_valid, in_ready, alu_a);
      end
      drive(32'h002081B3, 32'h0, 32'h0, 32'd3, 32'd0, 32'h0);
      step;
      total++;
      if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b0, 32'd1}) begin
         bad++;
         $display("FAIL b2b_hold: got v=%b r=%b a=%h exp v=1 r=0 a=1", out_valid, in_ready, alu_a);
      end
      out_ready = 1'b1;
      step;
      total++;
      if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b1, 32'd2}) begin
         bad++;
         $display("FAIL b2b_second: got v=%b r=%b a=%h exp v=1 r=1 a=2", out_valid, in_ready, alu_a);
      end
      step;
      in_valid = 1'b0;
      total++;
      if ({out_valid, alu_a} !== {1'b1, 32'd3}) begin
         bad++;
         $display("FAIL b2b_third: got v=%b a=%h exp v=1 a=3", out_valid, alu_a);
      end
      step;
      total++;
      if ({out_valid, in_ready, got} !== {1'b0, 1'b1, 72'd0}) begin
         bad++;
         $display("FAIL b2b_drain: got v=%b r=%b pay=%h exp empty", out_valid, in_ready, got);
      end
   endtask

   task automatic fill_two;
      out_ready = 1'b0;
      drive(32'h002081B3, 32'h0, 32'h0, 32'd11, 32'd0, 32'h0);
      in_valid = 1'b1;
      step;
      drive(32'h002081B3, 32'h0, 32'h0, 32'd12, 32'd0, 32'h0);
      step;
      drive(32'h002081B3, 32'h0, 32'h0, 32'd13, 32'd0, 32'h0);
   endtask

   task automatic test_flush;
      fill_two;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_setup: got r=%b exp r=0", in_ready);
      end
      flush = 1'b1;
      step;
      flush = 1'b0;
      in_valid = 1'b0;
      total++;
      if ({out_valid, in_ready, got} !== {1'b0, 1'b1, 72'd0}) begin
         bad++;
         $display("FAIL flush: got v=%b r=%b pay=%h exp empty", out_valid, in_ready, got);
      end
      out_ready = 1'b1;
      step; step;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_stale: got v=%b exp v=0", out_valid);
      end
   endtask

   task automatic test_reset_mid;
      fill_two;
      reset = 1'b1;
      step;
      reset = 1'b0;
      in_valid = 1'b0;
      total++;
      if ({out_valid, in_ready, got} !== {1'b0, 1'b1, 72'd0}) begin
         bad++;
         $display("FAIL reset_mid: got v=%b r=%b pay=%h exp empty", out_valid, in_ready, got);
      end
      out_ready = 1'b1;
      step; step;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_stale: got v=%b exp v=0", out_valid);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_decode;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
